fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetcher with a synchronous-read instruction
// memory, one outstanding read and a two-entry output buffer. A bad fetch address
// (misaligned or beyond the memory) produces a single fault entry and halts
// fetching until the next redirect.
module fetch_unit #(
    parameter int          NUM_INSTR = 1024,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_fault
);
    localparam int          AW          = (NUM_INSTR > 1) ? $clog2(NUM_INSTR) : 1;
    localparam logic [31:0] NUM_INSTR_W = 32'(NUM_INSTR);
    localparam logic [2:0]  BUF_W       = 3'(BUF_DEPTH);
    localparam logic [31:0] NOP         = 32'h0000_0013;

    typedef enum logic {FETCH = 1'b0, HALT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [31:0] fpc_q, fpc_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic [31:0] buf_pc_q    [2];
    logic [31:0] buf_pc_d    [2];
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_instr_d [2];
    logic        buf_fault_q [2];
    logic        buf_fault_d [2];

    // Attributes of the outstanding read; the memory word itself lands in rd_mem_q
    logic [31:0] rd_pc_q, rd_pc_d;
    logic        rd_fault_q, rd_fault_d;
    logic [31:0] rd_mem_q;

    logic [31:0] mem [NUM_INSTR];

    logic        pop;
    logic        push;
    logic        fetch_ok;
    logic        load_ok;
    logic        issue;
    logic [2:0]  occ;
    logic        unused_addr_bits;

    // Word-granular loads: the byte offset is deliberately ignored
    assign unused_addr_bits = ^load_addr[1:0];

    assign out_valid = (count_q != 2'd0);
    assign out_pc    = buf_pc_q[rd_ptr_q];
    assign out_instr = buf_instr_q[rd_ptr_q];
    assign out_fault = buf_fault_q[rd_ptr_q];

    // Decide whether a read issues this cycle; the returning read is the only push
    always_comb begin
        pop      = out_valid & out_ready;
        push     = inflight_q;
        fetch_ok = (fpc_q[1:0] == 2'b00) && ({2'b00, fpc_q[31:2]} < NUM_INSTR_W);
        load_ok  = ({2'b00, load_addr[31:2]} < NUM_INSTR_W);
        occ      = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        issue    = (state_q == FETCH) && !load_en && !redirect && (occ < BUF_W);
    end

    // Next-state for fetch PC, FSM, in-flight tracking and output buffer
    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        inflight_d  = inflight_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        buf_pc_d    = buf_pc_q;
        buf_instr_d = buf_instr_q;
        buf_fault_d = buf_fault_q;
        rd_pc_d     = rd_pc_q;
        rd_fault_d  = rd_fault_q;

        if (issue) begin
            rd_pc_d    = fpc_q;
            rd_fault_d = !fetch_ok;
        end

        if (redirect) begin
            // Flush everything buffered or outstanding and restart at the new PC
            count_d    = 2'd0;
            rd_ptr_d   = 1'b0;
            wr_ptr_d   = 1'b0;
            inflight_d = 1'b0;
            fpc_d      = redirect_pc;
            state_d    = FETCH;
        end else begin
            if (pop) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            if (push) begin
                buf_pc_d[wr_ptr_q]    = rd_pc_q;
                buf_instr_d[wr_ptr_q] = rd_fault_q ? NOP : rd_mem_q;
                buf_fault_d[wr_ptr_q] = rd_fault_q;
                wr_ptr_d              = ~wr_ptr_q;
            end
            count_d    = count_q + {1'b0, push} - {1'b0, pop};
            inflight_d = issue;
            if (issue) begin
                fpc_d = fpc_q + 32'd4;
                if (!fetch_ok) begin
                    state_d = HALT;
                end
            end
        end
    end

    // Control state and output buffer, cleared asynchronously
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= FETCH;
            fpc_q       <= RESET_PC;
            inflight_q  <= 1'b0;
            count_q     <= 2'd0;
            rd_ptr_q    <= 1'b0;
            wr_ptr_q    <= 1'b0;
            buf_pc_q    <= '{default: 32'h0};
            buf_instr_q <= '{default: 32'h0};
            buf_fault_q <= '{default: 1'b0};
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            inflight_q  <= inflight_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            buf_pc_q    <= buf_pc_d;
            buf_instr_q <= buf_instr_d;
            buf_fault_q <= buf_fault_d;
        end
    end

    // Instruction memory (read-before-write) and read-side data capture, never reset
    always_ff @(posedge clk) begin
        rd_pc_q    <= rd_pc_d;
        rd_fault_q <= rd_fault_d;
        if (issue && fetch_ok) begin
            rd_mem_q <= mem[fpc_q[AW+1:2]];
        end
        if (load_en && load_ok) begin
            mem[load_addr[AW+1:2]] <= load_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: drives two fetch_unit instances (1024-word and 16-word memories)
// with identical stimulus and compares both against a queue-level reference model.
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_ready = 1'b0;

    logic        ov0, ov1, of0, of1;
    logic [31:0] oi0, oi1, op0, op1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fetch_unit #(.NUM_INSTR(1024)) dut (
        .clk(clk), .n_rst(n_rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(ov0), .out_instr(oi0), .out_pc(op0),
        .out_fault(of0)
    );

    fetch_unit #(.NUM_INSTR(16)) dut16 (
        .clk(clk), .n_rst(n_rst), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .redirect(redirect), .redirect_pc(redirect_pc),
        .out_ready(out_ready), .out_valid(ov1), .out_instr(oi1), .out_pc(op1),
        .out_fault(of1)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } ent_t;

    // ---------------- reference model ----------------
    ent_t        mq   [2][$];
    logic [31:0] mm   [2][1024];
    logic [31:0] mfpc [2];
    bit          mhalt[2];
    bit          minf [2];
    ent_t        mfl  [2];

    function automatic int ni(int k);
        return (k == 0) ? 1024 : 16;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mq[k].delete();
            mfpc[k]  = 32'h0;
            mhalt[k] = 1'b0;
            minf[k]  = 1'b0;
        end
    endtask

    task automatic model_step(int k);
        bit          pop;
        bit          iss;
        int          occ;
        logic [31:0] idx;
        ent_t        ne;
        pop = (mq[k].size() > 0) && out_ready;
        occ = int'(mq[k].size()) + int'(minf[k]) - int'(pop);
        iss = !mhalt[k] && !load_en && !redirect && (occ < 2);
        idx = mfpc[k] >> 2;
        ne.pc = mfpc[k];
        if (mfpc[k][1:0] != 2'b00 || idx >= 32'(ni(k))) begin
            ne.instr = 32'h0000_0013;
            ne.fault = 1'b1;
        end else begin
            ne.instr = mm[k][idx];
            ne.fault = 1'b0;
        end
        if (redirect) begin
            mq[k].delete();
            minf[k]  = 1'b0;
            mfpc[k]  = redirect_pc;
            mhalt[k] = 1'b0;
        end else begin
            if (pop) void'(mq[k].pop_front());
            if (minf[k]) mq[k].push_back(mfl[k]);
            minf[k] = iss;
            mfl[k]  = ne;
            if (iss) begin
                mfpc[k] = mfpc[k] + 32'd4;
                if (ne.fault) mhalt[k] = 1'b1;
            end
        end
        if (load_en && (load_addr >> 2) < 32'(ni(k))) mm[k][load_addr >> 2] = load_data;
    endtask

    initial begin
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 1024; i++) mm[k][i] = 32'h0;
        model_reset();
        forever begin
            @(posedge clk or negedge n_rst);
            if (!n_rst) model_reset();
            else for (int k = 0; k < 2; k++) model_step(k);
        end
    end

    // ---------------- checking ----------------
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            for (int k = 0; k < 2; k++) begin
                logic        v, f;
                logic [31:0] p, ins;
                v   = (k == 0) ? ov0 : ov1;
                f   = (k == 0) ? of0 : of1;
                p   = (k == 0) ? op0 : op1;
                ins = (k == 0) ? oi0 : oi1;
                chk($sformatf("model out_valid dut%0d", k), 32'(v), 32'(mq[k].size() > 0));
                if (mq[k].size() > 0) begin
                    chk($sformatf("model out_pc dut%0d", k), p, mq[k][0].pc);
                    chk($sformatf("model out_instr dut%0d", k), ins, mq[k][0].instr);
                    chk($sformatf("model out_fault dut%0d", k), 32'(f), 32'(mq[k][0].fault));
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_in(bit le, logic [31:0] la, logic [31:0] ld,
                          bit rd, logic [31:0] rpc, bit rdy);
        load_en = le; load_addr = la; load_data = ld;
        redirect = rd; redirect_pc = rpc; out_ready = rdy;
    endtask

    task automatic wait_valid(int k, int budget, string name);
        int c;
        c = 0;
        while (((k == 0) ? ov0 : ov1) !== 1'b1 && c < budget) begin
            @(negedge clk);
            c++;
        end
        if (c >= budget) chk(name, 32'h0, 32'h1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    localparam logic [31:0] A0 = 32'hA000_0000;

    initial begin
        ent_t got[$];
        int   r;

        repeat (3) @(negedge clk);
        // Reset state
        chk("reset out_valid", 32'(ov0), 32'h0);
        chk("reset out_pc", op0, 32'h0);
        chk("reset out_instr", oi0, 32'h0);
        chk("reset out_fault", 32'(of0), 32'h0);

        // Preload every word (random byte offsets must be ignored)
        for (int i = 0; i < 1024; i++) begin
            set_in(1'b1, {i[29:0], 2'($urandom)}, $urandom, 1'b0, 32'h0, 1'($urandom));
            if (i == 0) #1 n_rst = 1'b1;
            @(negedge clk);
        end

        // Load A0..A3 then redirect to 0 with out_ready high
        for (int i = 0; i < 4; i++) begin
            set_in(1'b1, 32'(i * 4), A0 + 32'(i), 1'b0, 32'h0, 1'b1);
            @(negedge clk);
        end
        set_in(1'b0, 0, 0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
        chk("seq valid redirect+1", 32'(ov0), 32'h0);
        @(negedge clk);
        chk("seq valid redirect+2", 32'(ov0), 32'h0);
        @(negedge clk);
        for (int j = 0; j < 4; j++) begin
            chk("seq valid", 32'(ov0), 32'h1);
            chk("seq pc", op0, 32'(j * 4));
            chk("seq instr", oi0, A0 + 32'(j));
            @(negedge clk);
        end

        // Stall with out_ready low, then release
        set_in(1'b0, 0, 0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        set_in(1'b0, 0, 0, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("stall valid", 32'(ov0), 32'h1);
            chk("stall pc held", op0, 32'h0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain pc 4", op0, 32'h4);
        @(negedge clk);
        chk("drain pc 8", op0, 32'h8);
        out_ready = 1'b0;
        @(negedge clk);
        chk("full head pc 8", op0, 32'h8);

        // Redirect while buffer is full
        set_in(1'b0, 0, 0, 1'b1, 32'h40, 1'b0);
        @(negedge clk);
        set_in(1'b0, 0, 0, 1'b0, 32'h0, 1'b1);
        chk("flush valid", 32'(ov0), 32'h0);
        wait_valid(0, 10, "flush wait");
        chk("flush next pc", op0, 32'h40);

        // 16-word instance runs off the end of its memory
        set_in(1'b0, 0, 0, 1'b1, 32'h38, 1'b1);
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (ov1 === 1'b1) got.push_back('{pc: op1, instr: oi1, fault: of1});
        end
        chk("end entries", 32'(got.size()), 32'h3);
        if (got.size() == 3) begin
            chk("end pc0", got[0].pc, 32'h38);
            chk("end fault0", 32'(got[0].fault), 32'h0);
            chk("end pc1", got[1].pc, 32'h3C);
            chk("end fault1", 32'(got[1].fault), 32'h0);
            chk("end pc2", got[2].pc, 32'h40);
            chk("end fault2", 32'(got[2].fault), 32'h1);
            chk("end instr2", got[2].instr, 32'h0000_0013);
        end
        set_in(1'b0, 0, 0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        redirect = 1'b0;
        wait_valid(1, 10, "resume wait");
        chk("resume pc", op1, 32'h0);

        // Misaligned redirect, then out-of-range load
        got.delete();
        set_in(1'b0, 0, 0, 1'b1, 32'h6, 1'b1);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            redirect = 1'b0;
            if (ov0 === 1'b1) got.push_back('{pc: op0, instr: oi0, fault: of0});
        end
        chk("misalign entries", 32'(got.size()), 32'h1);
        if (got.size() == 1) begin
            chk("misalign pc", got[0].pc, 32'h6);
            chk("misalign fault", 32'(got[0].fault), 32'h1);
        end
        set_in(1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b1);
        @(negedge clk);
        set_in(1'b0, 0, 0, 1'b1, 32'h0, 1'b1);
        @(negedge clk);
        redirect = 1'b0;
        wait_valid(0, 10, "oob wait");
        chk("oob pc", op0, 32'h0);
        chk("oob mem[0] kept", oi0, A0);

        // Asynchronous reset mid-stream
        set_in(1'b0, 0, 0, 1'b1, 32'h0, 1'b0);
        @(negedge clk);
        redirect = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset valid", 32'(ov0), 32'h1);
        #2 n_rst = 1'b0;
        #1;
        chk("async reset valid", 32'(ov0), 32'h0);
        chk("async reset pc", op0, 32'h0);
        chk("async reset instr", oi0, 32'h0);
        chk("async reset fault", 32'(of0), 32'h0);
        @(negedge clk);
        #1 n_rst = 1'b1;
        out_ready = 1'b1;
        wait_valid(0, 10, "post-reset wait");
        chk("post-reset pc", op0, 32'h0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            load_en   = ($urandom % 6) == 0;
            load_addr = $urandom_range(0, 32'h1100);
            load_data = $urandom;
            redirect  = ($urandom % 12) == 0;
            r = $urandom % 8;
            if (r < 6)       redirect_pc = $urandom_range(0, 32'h7C) & 32'hFFFF_FFFC;
            else if (r == 6) redirect_pc = $urandom_range(0, 32'h7F) | 32'h1;
            else             redirect_pc = 32'hFFFF_FFF0;
            out_ready = ($urandom % 4) != 0;
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
